// File: rtl/mp1_mem_responder.sv
// Single-port word memory behind a held-request handshake with a fixed response latency.
// Protocol violations by the initiator latch a sticky err flag that only rst clears.
module mp1_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [3:0]            cnt;
    logic [31:0]           cap_addr;
    logic [31:0]           cap_wdata;
    logic [3:0]            cap_be;
    logic                  cap_write;
    logic                  cap_bad;
    logic [ADDR_WIDTH-1:0] cap_idx;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                  req_one;
    logic                  req_both;
    logic                  in_bad;
    logic                  req_dropped;
    logic                  req_changed;
    logic                  accept;
    logic                  enter_resp;
    logic                  err_set;

    logic [ADDR_WIDTH-1:0] txn_idx;
    logic [31:0]           txn_wdata;
    logic [3:0]            txn_be;
    logic                  txn_write;
    logic                  txn_bad;

    assign req_one     = mem_read ^ mem_write;
    assign req_both    = mem_read & mem_write;
    assign in_bad      = (mem_address >> (ADDR_WIDTH + 2)) != 32'd0;
    assign req_dropped = cap_write ? !mem_write : !mem_read;
    assign req_changed = (mem_address != cap_addr) || (mem_wdata != cap_wdata);
    assign mem_resp    = (state == RESP);

    // With LATENCY=1 the array is accessed on the accepting edge, before the
    // capture registers hold the request, so the live inputs are used instead.
    always_comb begin
        if (state == IDLE) begin
            txn_idx   = mem_address[ADDR_WIDTH+1:2];
            txn_wdata = mem_wdata;
            txn_be    = mem_byte_enable;
            txn_write = mem_write;
            txn_bad   = in_bad;
        end else begin
            txn_idx   = cap_idx;
            txn_wdata = cap_wdata;
            txn_be    = cap_be;
            txn_write = cap_write;
            txn_bad   = cap_bad;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        enter_resp = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (req_both) begin
                    err_set = 1'b1;
                end else if (req_one) begin
                    accept  = 1'b1;
                    err_set = in_bad;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // The counter reaching zero on this edge means the response cycle follows.
                if (req_dropped) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end else begin
                    err_set = req_changed;
                    if (cnt <= 4'd1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= 4'd0;
            mem_rdata <= 32'h0000_0000;
            err       <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
            cap_write <= 1'b0;
            cap_bad   <= 1'b0;
            cap_idx   <= '0;
        end else begin
            if (accept) begin
                cnt       <= 4'(LATENCY - 1);
                cap_addr  <= mem_address;
                cap_wdata <= mem_wdata;
                cap_be    <= mem_byte_enable;
                cap_write <= mem_write;
                cap_bad   <= in_bad;
                cap_idx   <= mem_address[ADDR_WIDTH+1:2];
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp && !txn_write) begin
                mem_rdata <= txn_bad ? 32'h0000_0000 : mem[txn_idx];
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // The array has no reset; rst only suppresses a write that would land on that edge.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && txn_write && !txn_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (txn_be[b]) begin
                    mem[txn_idx][8*b +: 8] <= txn_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mp1_mem_responder.sv
// Scoreboard bench for mp1_mem_responder: one instance at LATENCY=3 and one at LATENCY=1.
// Stimulus pushes expected responses; a negedge monitor pops and compares on every mem_resp.
module tb_mp1_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       rd_v;
    logic [1:0]       wr_v;
    logic [1:0][3:0]  be_v;
    logic [1:0][31:0] addr_v;
    logic [1:0][31:0] wdata_v;
    logic [1:0][31:0] rdata_v;
    logic [1:0]       resp_v;
    logic [1:0]       err_v;

    mp1_mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut_lat3 (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (rd_v[0]),
        .mem_write       (wr_v[0]),
        .mem_byte_enable (be_v[0]),
        .mem_address     (addr_v[0]),
        .mem_wdata       (wdata_v[0]),
        .mem_rdata       (rdata_v[0]),
        .mem_resp        (resp_v[0]),
        .err             (err_v[0])
    );

    mp1_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_lat1 (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (rd_v[1]),
        .mem_write       (wr_v[1]),
        .mem_byte_enable (be_v[1]),
        .mem_address     (addr_v[1]),
        .mem_wdata       (wdata_v[1]),
        .mem_rdata       (rdata_v[1]),
        .mem_resp        (resp_v[1]),
        .err             (err_v[1])
    );

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        is_read;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   resp_cnt[2] = '{0, 0};
    int   last_resp_cyc[2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    // Every mem_resp pulse must match the oldest outstanding expectation in cycle and data.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic have;
        for (int i = 0; i < 2; i++) begin
            if (resp_v[i] === 1'b1) begin
                resp_cnt[i]++;
                last_resp_cyc[i] = cyc;
                have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                total++;
                if (!have) begin
                    bad++;
                    $display("[TB] FAIL unexpected_resp dut%0d: got mem_resp=1 at cycle %0d, required 0", i, cyc);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    if (e.cyc != cyc) begin
                        bad++;
                        $display("[TB] FAIL resp_cycle dut%0d: got cycle %0d, required %0d", i, cyc, e.cyc);
                    end
                    if (e.is_read) begin
                        total++;
                        if (rdata_v[i] !== e.rdata) begin
                            bad++;
                            $display("[TB] FAIL rdata dut%0d: got %h, required %h", i, rdata_v[i], e.rdata);
                        end
                    end
                end
            end
        end
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int idx, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        rd_v[idx]    = rd;
        wr_v[idx]    = wr;
        addr_v[idx]  = addr;
        wdata_v[idx] = wdata;
        be_v[idx]    = be;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Issues one request, holds it until mem_resp, then drops it in the following cycle.
    task automatic applyStimulus(input int idx, input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp_rdata,
                                 input logic glitch = 1'b0, input logic [31:0] alt_addr = 32'd0);
        exp_t e;
        int   n0;
        drive(idx, rd, wr, addr, wdata, be);
        e.cyc     = cyc + ((idx == 0) ? 3 : 1);
        e.rdata   = exp_rdata;
        e.is_read = rd;
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
        n0 = resp_cnt[idx];
        for (int k = 0; k < 40 && resp_cnt[idx] == n0; k++) begin
            @(posedge clk);
            #1;
            if (glitch && k == 0) addr_v[idx] = alt_addr;
        end
        if (resp_cnt[idx] == n0) begin
            total++;
            bad++;
            $display("[TB] FAIL resp_timeout dut%0d: got no mem_resp, required one for addr %h", idx, addr);
            if (idx == 0) void'(q0.pop_back());
            else          void'(q1.pop_back());
        end
        rd_v[idx] = 1'b0;
        wr_v[idx] = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        stepCycles(2);
        checkOutput("reset_resp", {31'd0, resp_v[0]}, 32'd0);
        checkOutput("reset_rdata", rdata_v[0], 32'h0000_0000);
        checkOutput("reset_err", {31'd0, err_v[0]}, 32'd0);
        checkOutput("reset_rdata_l1", rdata_v[1], 32'h0000_0000);
        rst = 1'b0;
        stepCycles(1);

        $display("[TB] basic write/read at LATENCY=3");
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22BE44);
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22BE44);
        checkOutput("err_clean", {31'd0, err_v[0]}, 32'd0);
        stepCycles(3);
        checkOutput("rdata_hold", rdata_v[0], 32'hDE22BE44);

        $display("[TB] reset during BUSY");
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, 32'h0);
        drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'b1111);
        stepCycles(1);
        rst = 1'b1;
        stepCycles(1);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        stepCycles(4);
        checkOutput("rst_busy_rdata", rdata_v[0], 32'h0000_0000);
        checkOutput("rst_busy_err", {31'd0, err_v[0]}, 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, 32'hCAFEF00D);

        $display("[TB] address change during BUSY");
        applyStimulus(0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'b1111, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDE22BE44, 1'b1, 32'h14);
        checkOutput("err_addr_change", {31'd0, err_v[0]}, 32'd1);
        pulseReset();
        checkOutput("err_cleared_1", {31'd0, err_v[0]}, 32'd0);

        $display("[TB] request dropped during BUSY");
        drive(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        stepCycles(1);
        drive(0, 1'b0, 1'b0, 32'h30, 32'h0, 4'h0);
        stepCycles(4);
        checkOutput("err_abort", {31'd0, err_v[0]}, 32'd1);
        pulseReset();

        $display("[TB] out-of-range address");
        applyStimulus(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'b0000, 32'h0000_0000);
        checkOutput("err_oob", {31'd0, err_v[0]}, 32'd1);
        applyStimulus(0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 32'h0);
        stepCycles(5);
        checkOutput("err_sticky", {31'd0, err_v[0]}, 32'd1);
        pulseReset();
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0BADF00D);

        $display("[TB] read and write both high");
        drive(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'b1111);
        stepCycles(4);
        checkOutput("both_resp", {31'd0, resp_v[0]}, 32'd0);
        checkOutput("both_err", {31'd0, err_v[0]}, 32'd1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        stepCycles(1);
        pulseReset();
        checkOutput("both_rst_err", {31'd0, err_v[0]}, 32'd0);
        checkOutput("both_rst_rdata", rdata_v[0], 32'h0000_0000);

        $display("[TB] back-to-back at LATENCY=1");
        applyStimulus(1, 1'b0, 1'b1, 32'h0, 32'h01010101, 4'b1111, 32'h0);
        applyStimulus(1, 1'b0, 1'b1, 32'h4, 32'h02020202, 4'b1111, 32'h0);
        applyStimulus(1, 1'b0, 1'b1, 32'h0, 32'hAA000000, 4'b1000, 32'h0);
        s = cyc;
        applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 32'hAA010101);
        applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'b0000, 32'h02020202);
        checkOutput("b2b_span", 32'(last_resp_cyc[1] - s), 32'd3);
        checkOutput("l1_err", {31'd0, err_v[1]}, 32'd0);

        stepCycles(3);
        checkOutput("q0_drained", 32'(q0.size()), 32'd0);
        checkOutput("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mp1_mem_responder.md
MP1_MEM_RESPONDER -- requirements
Module: mp1_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, giving word-address bits (2**ADDR_WIDTH words of 32 bits).
REQ-002 SHALL have parameter LATENCY, default 3, giving cycles from request acceptance to mem_resp; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port mem_read  input  1  read request, held by initiator until mem_resp.
REQ-006 SHALL have port mem_write  input  1  write request, held by initiator until mem_resp.
REQ-007 SHALL have port mem_byte_enable  input  4  per-byte write mask; bit i covers bits 8i+7:8i.
REQ-008 SHALL have port mem_address  input  32  byte address; bits 1:0 ignored.
REQ-009 SHALL have port mem_wdata  input  32  write data.
REQ-010 SHALL have port mem_rdata  output  32  read data, valid only while mem_resp=1.
REQ-011 SHALL have port mem_resp  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 In IDLE, exactly one of mem_read/mem_write high SHALL capture address, wdata, byte enables and operation at the edge; counter loads LATENCY-1; next state BUSY, or RESP when LATENCY=1.
REQ-015 In BUSY, counter SHALL decrement each cycle; at counter 0 the next state is RESP.
REQ-016 If the request is first high in cycle 0, mem_resp SHALL be high in cycle LATENCY, for exactly one cycle.
REQ-017 RESP SHALL always return to IDLE.
REQ-018 A new request SHALL be acceptable in the cycle after RESP; back-to-back throughput is one transaction per LATENCY+1 cycles.
REQ-019 Word index SHALL be captured mem_address[ADDR_WIDTH+1:2].
REQ-020 Read SHALL register the array word into mem_rdata on the edge entering RESP.
REQ-021 Write SHALL update the enabled bytes on the edge entering RESP; disabled bytes SHALL remain unchanged; a write with mask 0000 still completes with mem_resp.
REQ-022 A read issued after a write completes SHALL return the written data.
REQ-023 mem_rdata SHALL hold its last value outside RESP.
REQ-024 Captured values SHALL be used for the whole transaction; if mem_address or mem_wdata changes during BUSY, err SHALL set.
REQ-025 If mem_address[31:ADDR_WIDTH+2] is nonzero: read returns 0, write is dropped, mem_resp still pulses, and err sets.
REQ-026 If mem_read and mem_write are both high in IDLE: no request is accepted, FSM stays IDLE, and err sets.
REQ-027 If the active request drops during BUSY: abort to IDLE, no mem_resp, no array write, and err sets.
REQ-028 err SHALL stay set until rst.

Reset
REQ-029 When rst=1 at an edge: state IDLE, counter 0, mem_resp 0, mem_rdata 0x00000000, err 0.
REQ-030 rst SHALL take priority over all request activity; reset during BUSY aborts with no array write and no mem_resp.
REQ-031 Array contents SHALL NOT be cleared by rst.

Verification
REQ-032 LATENCY=3: write 0xDEADBEEF, mask 1111, address 0x00000010 in cycle 0 -> mem_resp high in cycle 3 only; then read 0x10 -> mem_rdata=0xDEADBEEF with mem_resp.
REQ-033 Word 0x10 holds 0xDEADBEEF; write 0x11223344 with mask 0101 -> subsequent read returns 0xDE22BE44.
REQ-034 LATENCY=1: back-to-back reads of 0x0 and 0x4 -> mem_resp in cycles 1 and 3; FSM passes through RESP and IDLE between them.
REQ-035 Read of 0x00001000 (ADDR_WIDTH=10) -> mem_rdata=0, mem_resp pulses, err=1 and stays 1.
REQ-036 mem_read and mem_write both high -> no mem_resp, err=1; then rst pulse -> err=0, mem_rdata=0.
REQ-037 Write to 0x20 with rst asserted in cycle 1 -> no mem_resp; later read of 0x20 returns its prior contents.
